// File: rtl/iob_eth_rx_packer.sv
// iob_eth_rx_packer: reads a received frame byte by byte from the RX buffer and packs it little-endian into DATA_W-bit words
// Ports:
//   clk_i, cke_i, rst_i        clock, clock enable, synchronous active-high reset
//   start_i, abort_i, nbytes_i frame control: start packing nbytes_i bytes / drop the current frame
//   busy_o, done_o             frame in progress / one-cycle completion pulse
//   buf_ren_o, buf_addr_o      RX buffer byte read port (1-cycle latency)
//   buf_rdata_i                RX buffer read data
//   word_valid_o, word_ready_i word stream handshake
//   word_data_o, word_wstrb_o  packed word and lane strobes
//   word_last_o                final word of the frame
module iob_eth_rx_packer #(
   parameter int BUFFER_W = 11,
   parameter int DATA_W   = 32
) (
   input  logic                  clk_i,
   input  logic                  cke_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [BUFFER_W-1:0]   nbytes_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  buf_ren_o,
   output logic [BUFFER_W-1:0]   buf_addr_o,
   input  logic [7:0]            buf_rdata_i,
   output logic                  word_valid_o,
   input  logic                  word_ready_i,
   output logic [DATA_W-1:0]     word_data_o,
   output logic [DATA_W/8-1:0]   word_wstrb_o,
   output logic                  word_last_o
);
   localparam int NB = DATA_W / 8;
   localparam int LW = $clog2(NB) + 1;
   localparam logic [BUFFER_W-1:0] NB_B  = BUFFER_W'(NB);
   localparam logic [BUFFER_W-1:0] ONE_B = BUFFER_W'(1);
   localparam logic [LW-1:0]       NB_L  = LW'(NB);
   localparam logic [LW-1:0]       ONE_L = LW'(1);
   typedef enum logic [1:0] {IDLE, READ, OUT, DONE} state_t;
   state_t              state;
   logic [BUFFER_W-1:0] n;
   logic [BUFFER_W-1:0] bcnt;
   logic [LW-1:0]       iss;
   logic [LW-1:0]       wlen;
   logic [LW-1:0]       rd_lane;
   logic                rd_pend;
   logic [BUFFER_W-1:0] rem;
   logic [LW-1:0]       wlen_nx;
   // bytes still to read, measured at the start of the next word
   assign rem        = (state == IDLE) ? nbytes_i : n - bcnt;
   assign wlen_nx    = (rem >= NB_B) ? NB_L : rem[LW-1:0];
   assign buf_addr_o = bcnt;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         n            <= '0;
         bcnt         <= '0;
         iss          <= '0;
         wlen         <= '0;
         rd_lane      <= '0;
         rd_pend      <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         buf_ren_o    <= 1'b0;
         word_valid_o <= 1'b0;
         word_data_o  <= '0;
         word_wstrb_o <= '0;
         word_last_o  <= 1'b0;
      end else if (cke_i) begin
         if (abort_i) begin
            state        <= IDLE;
            bcnt         <= '0;
            rd_pend      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            buf_ren_o    <= 1'b0;
            word_valid_o <= 1'b0;
            word_data_o  <= '0;
            word_wstrb_o <= '0;
            word_last_o  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start_i) begin
                  n            <= nbytes_i;
                  bcnt         <= '0;
                  word_data_o  <= '0;
                  word_wstrb_o <= '0;
                  busy_o       <= 1'b1;
                  if (nbytes_i == '0) state <= DONE;
                  else begin
                     state     <= READ;
                     buf_ren_o <= 1'b1;
                     iss       <= '0;
                     wlen      <= wlen_nx;
                  end
               end
               READ: begin
                  if (buf_ren_o) begin
                     bcnt      <= bcnt + ONE_B;
                     iss       <= iss + ONE_L;
                     buf_ren_o <= (iss + ONE_L) < wlen;
                  end
                  rd_pend <= buf_ren_o;
                  rd_lane <= iss;
                  if (rd_pend) begin
                     for (int k = 0; k < NB; k++)
                        if (rd_lane == LW'(k)) begin
                           word_data_o[8*k +: 8] <= buf_rdata_i;
                           word_wstrb_o[k]       <= 1'b1;
                        end
                     // all issues for this word are done by now, so bcnt already points past it
                     if (rd_lane == wlen - ONE_L) begin
                        state        <= OUT;
                        word_valid_o <= 1'b1;
                        word_last_o  <= bcnt == n;
                     end
                  end
               end
               OUT: if (word_ready_i) begin
                  word_valid_o <= 1'b0;
                  word_last_o  <= 1'b0;
                  word_data_o  <= '0;
                  word_wstrb_o <= '0;
                  if (word_last_o) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                  end else begin
                     state     <= READ;
                     buf_ren_o <= 1'b1;
                     iss       <= '0;
                     wlen      <= wlen_nx;
                  end
               end
               DONE: begin
                  // a zero-length frame arrives here without done_o raised and spends one extra cycle
                  if (done_o) begin
                     done_o <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_iob_eth_rx_packer.sv
// tb_iob_eth_rx_packer: directed frames against a word-list model of the packer
module tb_iob_eth_rx_packer;
   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
   } word_t;
   logic        clk_i = 1'b0;
   logic        cke_i = 1'b1;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [10:0] nbytes_i = '0;
   logic        busy_o, done_o, buf_ren_o, word_valid_o, word_last_o;
   logic [10:0] buf_addr_o;
   logic [7:0]  buf_rdata_i = '0;
   logic        word_ready_i = 1'b1;
   logic [31:0] word_data_o;
   logic [3:0]  word_wstrb_o;
   logic [7:0]  mem [0:2047];
   word_t       exp_q[$];
   word_t       got_q[$];
   int          hs_q[$];
   int          n_checks = 0, n_fail = 0;
   int          cyc = 0, start_cyc = 0, hs_cyc = 0, valid_cyc = 0;
   int          cur_n = 0, exp_addr = 0, done_cnt = 0;
   bit          seen_valid = 0, prev_hold = 0, prev_resume = 0;
   logic [31:0] prev_d;
   logic [3:0]  prev_s;
   logic        prev_l;
   iob_eth_rx_packer dut (
      .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .nbytes_i(nbytes_i), .busy_o(busy_o), .done_o(done_o), .buf_ren_o(buf_ren_o),
      .buf_addr_o(buf_addr_o), .buf_rdata_i(buf_rdata_i), .word_valid_o(word_valid_o),
      .word_ready_i(word_ready_i), .word_data_o(word_data_o), .word_wstrb_o(word_wstrb_o),
      .word_last_o(word_last_o)
   );
   initial forever #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   always @(posedge clk_i) if (buf_ren_o) buf_rdata_i <= mem[buf_addr_o];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   always @(negedge clk_i) begin
      if (prev_hold) begin
         chk("hold_valid", word_valid_o, 1);
         chk("hold_data", word_data_o, prev_d);
         chk("hold_wstrb", word_wstrb_o, prev_s);
         chk("hold_last", word_last_o, prev_l);
      end
      if (prev_resume) chk("resume_read", buf_ren_o, 1);
      if (buf_ren_o) begin
         chk("rd_addr", buf_addr_o, exp_addr);
         chk("rd_in_range", buf_addr_o < cur_n, 1);
         chk("rd_while_valid", word_valid_o, 0);
         exp_addr++;
      end
      if (word_valid_o) begin
         if (!seen_valid) begin
            seen_valid = 1;
            valid_cyc = cyc;
         end
         chk("word_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            chk("word_data", word_data_o, exp_q[0].d);
            chk("word_wstrb", word_wstrb_o, exp_q[0].s);
            chk("word_last", word_last_o, exp_q[0].l);
         end
         if (word_ready_i && !abort_i && !rst_i) begin
            got_q.push_back({word_data_o, word_wstrb_o, word_last_o});
            hs_q.push_back(cyc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            hs_cyc = cyc;
         end
      end
      if (done_o) begin
         done_cnt++;
         chk("done_timing", cyc, cur_n == 0 ? start_cyc + 2 : hs_cyc + 1);
         chk("words_left", exp_q.size(), 0);
         chk("bytes_read", exp_addr, cur_n);
         chk("busy_at_done", busy_o, 0);
      end
      prev_hold   = word_valid_o && !word_ready_i && !abort_i && !rst_i;
      prev_resume = word_valid_o && word_ready_i && !word_last_o && !abort_i && !rst_i;
      prev_d = word_data_o;
      prev_s = word_wstrb_o;
      prev_l = word_last_o;
   end
   task automatic build(input int n);
      word_t w;
      int nw;
      nw = (n + 3) / 4;
      exp_q.delete();
      got_q.delete();
      hs_q.delete();
      for (int i = 0; i < nw; i++) begin
         w = '0;
         for (int k = 0; k < 4; k++)
            if (i * 4 + k < n) begin
               w.d[8*k +: 8] = mem[i*4+k];
               w.s[k] = 1'b1;
            end
         w.l = (i == nw - 1);
         exp_q.push_back(w);
      end
      cur_n = n;
      exp_addr = 0;
      seen_valid = 0;
   endtask
   task automatic run_frame(input int n, input int stall, input bit mid_start);
      int sl;
      bit fin;
      sl = stall;
      fin = 0;
      build(n);
      start_i = 1'b1;
      nbytes_i = 11'(n);
      start_cyc = cyc;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int i = 0; i < 6000 && !fin; i++) begin
         word_ready_i = !(word_valid_o && sl > 0);
         if (word_valid_o && sl > 0) sl--;
         start_i = mid_start && (i == 3);
         if (start_i) nbytes_i = 11'd3;
         @(posedge clk_i); #1;
         if (done_o) fin = 1;
      end
      start_i = 1'b0;
      word_ready_i = 1'b1;
      chk("frame_finished", fin, 1);
      @(posedge clk_i); #1;
   endtask
   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_ren"}, buf_ren_o, 0);
      chk({tag, "_valid"}, word_valid_o, 0);
      chk({tag, "_data"}, word_data_o, 0);
      chk({tag, "_wstrb"}, word_wstrb_o, 0);
      chk({tag, "_last"}, word_last_o, 0);
   endtask
   task automatic abort_test(input bit use_rst);
      bit hit;
      int d0;
      hit = 0;
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);
      build(100);
      start_i = 1'b1;
      nbytes_i = 11'd100;
      start_cyc = cyc;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (buf_ren_o && buf_addr_o == 11'd9) hit = 1;
         else begin
            @(posedge clk_i); #1;
         end
      end
      chk("abort_point", hit, 1);
      d0 = done_cnt;
      if (use_rst) rst_i = 1'b1;
      else abort_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      abort_i = 1'b0;
      exp_q.delete();
      cur_n = 0;
      if (use_rst) begin
         check_idle_outputs("rst");
         chk("rst_addr", buf_addr_o, 0);
      end else begin
         chk("abort_busy", busy_o, 0);
         chk("abort_ren", buf_ren_o, 0);
         chk("abort_valid", word_valid_o, 0);
      end
      repeat (6) @(posedge clk_i);
      #1;
      chk("no_done_after_stop", done_cnt, d0);
      chk("quiet_after_stop", buf_ren_o | word_valid_o | busy_o, 0);
      run_frame(8, 0, 0);
      chk("after_stop_words", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("after_stop_w0", got_q[0].d, 32'h18110A03);
         chk("after_stop_w1", got_q[1].d, 32'h342D261F);
         chk("after_stop_last", {got_q[0].l, got_q[1].l}, 2'b01);
      end
   endtask
   initial begin
      int tot;
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      repeat (3) @(posedge clk_i);
      #1;
      check_idle_outputs("reset");
      chk("reset_addr", buf_addr_o, 0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      for (int i = 0; i < 4; i++) mem[i] = 8'((i + 1) * 8'h11);
      run_frame(4, 0, 0);
      chk("full_valid_cycle", valid_cyc - start_cyc, 6);
      chk("full_words", got_q.size(), 1);
      if (got_q.size() == 1) chk("full_word", got_q[0], {32'h44332211, 4'b1111, 1'b1});
      for (int i = 0; i < 6; i++) mem[i] = 8'((i + 1) * 8'h11);
      run_frame(6, 0, 0);
      chk("partial_words", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("partial_w0", got_q[0], {32'h44332211, 4'b1111, 1'b0});
         chk("partial_w1", got_q[1], {32'h00006655, 4'b0011, 1'b1});
      end
      run_frame(6, 5, 0);
      chk("bp_words", got_q.size(), 2);
      if (hs_q.size() != 0) chk("bp_hs_cycle", hs_q[0] - start_cyc, 11);
      run_frame(0, 0, 0);
      chk("zero_words", got_q.size(), 0);
      chk("zero_no_valid", seen_valid, 0);
      for (int i = 0; i < 12; i++) mem[i] = 8'(8'hA0 + i);
      run_frame(12, 0, 1);
      chk("midstart_words", got_q.size(), 3);
      if (got_q.size() == 3) chk("midstart_w2", got_q[2], {32'hABAAA9A8, 4'b1111, 1'b1});
      abort_test(0);
      abort_test(1);
      for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
      run_frame(1518, 0, 0);
      chk("max_words", got_q.size(), 380);
      tot = 0;
      foreach (got_q[i]) tot += $countones(got_q[i].s);
      chk("max_bytes", tot, 1518);
      if (got_q.size() == 380) begin
         chk("max_first", got_q[0].d, 32'h03020100);
         chk("max_last", got_q[379], {32'h0000EDEC, 4'b0011, 1'b1});
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
